piece_stamp_engine: RTL and testbench
=====================================

// Module: piece_stamp_engine
// PURPOSE
//  Sequential, parametrised piece/board compositor for the game clock domain.
//  Stamps an NxN piece bitmap onto a WxH board one piece row per cycle.
//  Modes: OVERLAY (set cells), ERASE (clear cells), CHECK (collision test only).
//  Sits between the piece controller and the locked-board/frame path; used for
//  move legality checks, frame composition and piece locking.
// PARAMETERS
//  BOARD_W   10  board columns (x)
//  BOARD_H   20  board rows (y)
//  PIECE_N   4   piece grid edge; piece is PIECE_N x PIECE_N
//  COORD_W   6   signed width of piece origin x/y (two's complement)
// PORTS
//  clk          in   1                clock
//  reset        in   1                async, active-high reset
//  start        in   1                request; accepted only when busy==0
//  mode         in   2                00 OVERLAY, 01 CHECK, 10 ERASE, 11 = CHECK
//  base_board   in   BOARD_W*BOARD_H  cell (x,y) at bit x*BOARD_H+y
//  piece        in   PIECE_N*PIECE_N  cell (dx,dy) at bit dx*PIECE_N+dy
//  piece_x      in   COORD_W          signed origin column of piece cell (0,0)
//  piece_y      in   COORD_W          signed origin row of piece cell (0,0)
//  busy         out  1                high from cycle after accept until done
//  done         out  1                one-cycle pulse, result valid
//  result_board out  BOARD_W*BOARD_H  composed board (held until next accept)
//  collision    out  1                any piece cell illegal (held)
//  cell_count   out  $clog2(PIECE_N*PIECE_N+1)  piece cells modified (held)
// BEHAVIOUR
//  Reset (async): state IDLE; busy=0, done=0, collision=0, cell_count=0,
//   result_board=0. Reset mid-SCAN aborts; no done pulse is produced.
//  FSM: IDLE -> SCAN on start&&!busy; SCAN runs rows dy=0..PIECE_N-1, one per
//   cycle; after dy=PIECE_N-1 -> DONE; DONE (1 cycle, done=1) -> IDLE.
//  Accept cycle: register mode, piece, piece_x, piece_y; load working board
//   from base_board; clear collision and cell_count. busy=1 next cycle.
//  Latency: done asserts exactly PIECE_N+1 cycles after the accept edge.
//  start while busy/DONE: ignored; no queueing. Inputs after accept ignored.
//  Per set piece cell: bx = piece_x + dx, by = piece_y + dy, computed signed
//   at COORD_W+1 bits (no wrap-around).
//   - bx<0 or bx>=BOARD_W or by>=BOARD_H: collision=1; cell not written.
//   - by<0 (above board, legal spawn zone): no collision, not written.
//   - in bounds and base cell set: collision=1 (all modes except ERASE).
//   - in bounds: OVERLAY sets cell, ERASE clears cell, CHECK writes nothing;
//     cell_count++ when OVERLAY/ERASE actually targets an in-bounds cell
//     (CHECK: count of in-bounds cells that would be written).
//  ERASE never flags overlap; bounds violations still flag collision.
//  Empty piece (all zero): done after PIECE_N+1, collision=0, count=0,
//   result_board==base_board.
//  result_board/collision/cell_count update only on DONE entry; stable otherwise.
//  Overlay result never depends on collision: legal cells are stamped even if
//   another cell collided.
// TESTING
//  T1 OVERLAY, empty base, O-piece bits (1,1),(2,1),(1,2),(2,2), x=3,y=0 ->
//     cells (4,1),(5,1),(4,2),(5,2) set, collision=0, count=4, done @ +5 cycles.
//  T2 CHECK, base cell (5,1) set, same piece/pos -> collision=1,
//     result_board==base_board, count=4.
//  T3 OVERLAY, I-piece column dx=0 dy=0..3, x=9,y=17 -> (9,17),(9,18),(9,19)
//     set, row 20 dropped, collision=1, count=3.
//  T4 OVERLAY, I-piece row dy=0 dx=0..3, x=-1,y=-1 -> nothing written,
//     collision=1 (bx=-1), count=0; repeat with x=0,y=-1 -> collision=0.
//  T5 ERASE on full base, O-piece x=0,y=0 -> those 4 cells cleared,
//     collision=0, count=4; start pulsed again while busy -> ignored.
//  T6 assert reset 2 cycles into SCAN -> all outputs 0 same cycle, no done;
//     new start after release completes normally.

Source files
------------

// File: rtl/piece_stamp_engine_if.sv
// piece_stamp_engine_if: request/result bundle between piece controller and stamp engine
interface piece_stamp_engine_if #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int PIECE_N = 4,
  parameter int COORD_W = 6
);
  localparam int CNT_W = $clog2(PIECE_N*PIECE_N+1);
  logic                       start;
  logic [1:0]                 mode;
  logic [BOARD_W*BOARD_H-1:0] base_board;
  logic [PIECE_N*PIECE_N-1:0] piece;
  logic [COORD_W-1:0]         piece_x;
  logic [COORD_W-1:0]         piece_y;
  logic                       busy;
  logic                       done;
  logic [BOARD_W*BOARD_H-1:0] result_board;
  logic                       collision;
  logic [CNT_W-1:0]           cell_count;
  modport master (output start, mode, base_board, piece, piece_x, piece_y,
                  input busy, done, result_board, collision, cell_count);
  modport slave  (input start, mode, base_board, piece, piece_x, piece_y,
                  output busy, done, result_board, collision, cell_count);
endinterface

// File: rtl/piece_stamp_engine.sv
// piece_stamp_engine: stamps an NxN piece onto a WxH board one piece row per cycle
module piece_stamp_engine #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int PIECE_N = 4,
  parameter int COORD_W = 6
) (
  input logic                clk,
  input logic                reset,
  piece_stamp_engine_if.slave bus
);
  localparam int CELLS  = BOARD_W*BOARD_H;
  localparam int CNT_W  = $clog2(PIECE_N*PIECE_N+1);
  localparam int ROW_W  = $clog2(PIECE_N+1);
  localparam int IDX_W  = $clog2(CELLS);
  localparam int PIDX_W = $clog2(PIECE_N*PIECE_N);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  state_e                   state_q, state_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [1:0]               mode_q, mode_d;
  logic [PIECE_N*PIECE_N-1:0] piece_q, piece_d;
  logic [COORD_W-1:0]       px_q, px_d, py_q, py_d;
  logic [CELLS-1:0]         work_q, work_d, res_board_q, res_board_d, row_work;
  logic                     coll_q, coll_d, res_coll_q, res_coll_d, row_coll;
  logic [CNT_W-1:0]         cnt_q, cnt_d, res_cnt_q, res_cnt_d, row_cnt;
  logic [IDX_W-1:0]         idx;
  logic [PIDX_W-1:0]        pidx;
  int                       bx, by;
  // Row evaluation: per-cell bounds, overlap and write for the current piece row
  always_comb begin
    row_work = work_q;
    row_coll = 1'b0;
    row_cnt  = '0;
    bx = 0;
    by = 0;
    idx = '0;
    pidx = '0;
    if (row_q < ROW_W'(PIECE_N)) begin
      for (int d = 0; d < PIECE_N; d++) begin
        pidx = PIDX_W'(d*PIECE_N + int'(row_q));
        bx = int'($signed(px_q)) + d;
        by = int'($signed(py_q)) + int'(row_q);
        idx = IDX_W'(bx*BOARD_H + by);
        if (piece_q[pidx]) begin
          if (bx < 0 || bx >= BOARD_W || by >= BOARD_H) row_coll = 1'b1;
          else if (by >= 0) begin
            row_cnt = row_cnt + CNT_W'(1);
            if (mode_q != 2'b10 && work_q[idx]) row_coll = 1'b1;
            if (mode_q == 2'b00) row_work[idx] = 1'b1;
            if (mode_q == 2'b10) row_work[idx] = 1'b0;
          end
        end
      end
    end
  end
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    mode_d      = mode_q;
    piece_d     = piece_q;
    px_d        = px_q;
    py_d        = py_q;
    work_d      = work_q;
    coll_d      = coll_q;
    cnt_d       = cnt_q;
    res_board_d = res_board_q;
    res_coll_d  = res_coll_q;
    res_cnt_d   = res_cnt_q;
    if (state_q == IDLE && bus.start) begin
      state_d = SCAN;
      row_d   = '0;
      mode_d  = bus.mode;
      piece_d = bus.piece;
      px_d    = bus.piece_x;
      py_d    = bus.piece_y;
      work_d  = bus.base_board;
      coll_d  = 1'b0;
      cnt_d   = '0;
    end else if (state_q == SCAN) begin
      if (row_q == ROW_W'(PIECE_N)) begin
        state_d     = DONE;
        res_board_d = work_q;
        res_coll_d  = coll_q;
        res_cnt_d   = cnt_q;
      end else begin
        row_d  = row_q + ROW_W'(1);
        work_d = row_work;
        coll_d = coll_q | row_coll;
        cnt_d  = cnt_q + row_cnt;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      mode_q      <= '0;
      piece_q     <= '0;
      px_q        <= '0;
      py_q        <= '0;
      work_q      <= '0;
      coll_q      <= 1'b0;
      cnt_q       <= '0;
      res_board_q <= '0;
      res_coll_q  <= 1'b0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      piece_q     <= piece_d;
      px_q        <= px_d;
      py_q        <= py_d;
      work_q      <= work_d;
      coll_q      <= coll_d;
      cnt_q       <= cnt_d;
      res_board_q <= res_board_d;
      res_coll_q  <= res_coll_d;
      res_cnt_q   <= res_cnt_d;
    end
  end
  assign bus.busy         = state_q == SCAN;
  assign bus.done         = state_q == DONE;
  assign bus.result_board = res_board_q;
  assign bus.collision    = res_coll_q;
  assign bus.cell_count   = res_cnt_q;
endmodule

// File: tb/tb_piece_stamp_engine.sv
// tb_piece_stamp_engine: directed and random stamps against a cell-level board model
module tb_piece_stamp_engine;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int passed = 0;
  piece_stamp_engine_if bus ();
  piece_stamp_engine dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic void model(input logic [1:0] m, input logic [199:0] base, input logic [15:0] pc,
                                input int x, input int y, output logic [199:0] res,
                                output logic col, output int cnt);
    res = base;
    col = 1'b0;
    cnt = 0;
    for (int dx = 0; dx < 4; dx++)
      for (int dy = 0; dy < 4; dy++)
        if (pc[dx*4+dy]) begin
          int cx, cy;
          cx = x + dx;
          cy = y + dy;
          if (cx < 0 || cx >= 10 || cy >= 20) col = 1'b1;
          else if (cy >= 0) begin
            cnt++;
            if (m != 2'b10 && base[cx*20+cy]) col = 1'b1;
            if (m == 2'b00) res[cx*20+cy] = 1'b1;
            if (m == 2'b10) res[cx*20+cy] = 1'b0;
          end
        end
  endfunction
  task automatic run(input string tag, input logic [1:0] m, input logic [199:0] base,
                     input logic [15:0] pc, input int x, input int y, input bit poke);
    logic [199:0] er;
    logic ec;
    int en, n;
    model(m, base, pc, x, y, er, ec, en);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = m;
    bus.base_board = base;
    bus.piece = pc;
    bus.piece_x = 6'(x);
    bus.piece_y = 6'(y);
    @(posedge clk);
    #1;
    bus.start = poke;
    if (poke) begin
      bus.mode = 2'($urandom);
      bus.piece = 16'($urandom);
      bus.piece_x = 6'($urandom);
      bus.piece_y = 6'($urandom);
      bus.base_board = ~base;
    end
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) chk({tag, "_busy"}, 200'(bus.busy), 200'(1));
      if (bus.done) break;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, 200'(n), 200'(5));
    chk({tag, "_board"}, bus.result_board, er);
    chk({tag, "_coll"}, 200'(bus.collision), 200'(ec));
    chk({tag, "_count"}, 200'(bus.cell_count), 200'(en));
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 200'(bus.done), 200'(0));
    @(posedge clk);
    #1;
    chk({tag, "_hold"}, bus.result_board, er);
  endtask
  initial begin
    logic [199:0] base, t1;
    int seen;
    bus.start = 1'b0;
    bus.mode = '0;
    bus.base_board = '0;
    bus.piece = '0;
    bus.piece_x = '0;
    bus.piece_y = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_board", bus.result_board, 200'(0));
    chk("rst_flags", 200'({bus.busy, bus.done, bus.collision}), 200'(0));
    chk("rst_count", 200'(bus.cell_count), 200'(0));
    @(negedge clk);
    reset = 1'b0;
    run("t1", 2'b00, 200'(0), 16'h0660, 3, 0, 1'b0);
    t1 = '0;
    t1[81] = 1'b1;
    t1[82] = 1'b1;
    t1[101] = 1'b1;
    t1[102] = 1'b1;
    chk("t1_cells", bus.result_board, t1);
    base = '0;
    base[101] = 1'b1;
    run("t2", 2'b01, base, 16'h0660, 3, 0, 1'b0);
    chk("t2_base", bus.result_board, base);
    run("t3", 2'b00, 200'(0), 16'h000F, 9, 17, 1'b0);
    run("t4a", 2'b00, 200'(0), 16'h1111, -1, -1, 1'b0);
    run("t4b", 2'b00, 200'(0), 16'h1111, 0, -1, 1'b0);
    run("t5", 2'b10, ~200'(0), 16'h0660, 0, 0, 1'b1);
    run("empty", 2'b00, {7{32'hA5C3_1E77}}, 16'h0000, 2, 5, 1'b0);
    run("pre6", 2'b00, 200'(0), 16'h0660, 3, 0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 2'b00;
    bus.base_board = '0;
    bus.piece = 16'h0660;
    bus.piece_x = 6'd1;
    bus.piece_y = 6'd1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_board", bus.result_board, 200'(0));
    chk("t6_flags", 200'({bus.busy, bus.done, bus.collision}), 200'(0));
    chk("t6_count", 200'(bus.cell_count), 200'(0));
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1;
    end
    chk("t6_nodone", 200'(seen), 200'(0));
    run("t6_after", 2'b00, 200'(0), 16'h0660, 3, 0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [199:0] rb;
      logic [15:0] pc;
      int x, y;
      for (int w = 0; w < 7; w++) rb[w*32 +: 32] = $urandom & $urandom;
      pc = (i % 8 == 0) ? 16'h0 : 16'($urandom);
      x = (i % 10 == 0) ? int'($urandom_range(0, 63)) - 32 : int'($urandom_range(0, 15)) - 4;
      y = (i % 10 == 0) ? int'($urandom_range(0, 63)) - 32 : int'($urandom_range(0, 25)) - 4;
      run("rand", 2'($urandom), rb, pc, x, y, (i % 3) == 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
